// File: rtl/id_stage_pipe.sv
// MIPS ID stage: register file with write-first bypass, immediate extension,
// load-use hazard detection and an ID/EX register with stall, bubble and flush.
module id_stage_pipe #(
    parameter int NB_ADDR      = 32,
    parameter int NB_INST      = 32,
    parameter int NB_DATA      = 32,
    parameter int NB_REG       = 5,
    parameter int NB_IMMEDIATE = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic [NB_INST-1:0] i_instruction,
    input  logic               i_wb_write,
    input  logic [NB_REG-1:0]  i_wb_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic               i_ex_mem_read,
    input  logic [NB_REG-1:0]  i_ex_rt,
    input  logic               i_ex_stall,
    input  logic               i_flush,
    output logic               o_stall,
    output logic               o_valid,
    output logic [NB_ADDR-1:0] o_pc,
    output logic [NB_INST-1:0] o_instruction,
    output logic [5:0]         o_opcode,
    output logic [5:0]         o_funct,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_rd,
    output logic [NB_DATA-1:0] o_data_1,
    output logic [NB_DATA-1:0] o_data_2,
    output logic [NB_DATA-1:0] o_sign_extend
);

    localparam int DEPTH = 2 ** NB_REG;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;

    typedef struct packed {
        logic               valid;
        logic [NB_ADDR-1:0] pc;
        logic [NB_INST-1:0] instr;
        logic [5:0]         opcode;
        logic [5:0]         funct;
        logic [NB_REG-1:0]  rs;
        logic [NB_REG-1:0]  rt;
        logic [NB_REG-1:0]  rd;
        logic [NB_DATA-1:0] data_1;
        logic [NB_DATA-1:0] data_2;
        logic [NB_DATA-1:0] ext;
    } idex_t;

    logic [NB_DATA-1:0]      regfile_r [DEPTH];
    idex_t                   idex_r;
    idex_t                   idex_next_s;
    logic [5:0]              opcode_s;
    logic [5:0]              funct_s;
    logic [NB_REG-1:0]       rs_s;
    logic [NB_REG-1:0]       rt_s;
    logic [NB_REG-1:0]       rd_s;
    logic [NB_IMMEDIATE-1:0] imm_s;
    logic [NB_DATA-1:0]      rdata_1_s;
    logic [NB_DATA-1:0]      rdata_2_s;
    logic [NB_DATA-1:0]      ext_s;
    logic                    wb_en_s;
    logic                    hazard_s;

    assign opcode_s = i_instruction[31:26];
    assign funct_s  = i_instruction[5:0];
    assign rs_s     = NB_REG'(i_instruction[25:21]);
    assign rt_s     = NB_REG'(i_instruction[20:16]);
    assign rd_s     = NB_REG'(i_instruction[15:11]);
    assign imm_s    = i_instruction[NB_IMMEDIATE-1:0];
    assign wb_en_s  = i_wb_write && (i_wb_addr != {NB_REG{1'b0}});

    // Register file storage; entry 0 is never written so it stays zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regfile_r[i] <= {NB_DATA{1'b0}};
            end
        end else if (wb_en_s) begin
            regfile_r[i_wb_addr] <= i_wb_data;
        end else begin
            regfile_r[i_wb_addr] <= regfile_r[i_wb_addr];
        end
    end

    // Read ports with r0 forced to zero and write-first bypass from writeback.
    always_comb begin
        rdata_1_s = regfile_r[rs_s];
        rdata_2_s = regfile_r[rt_s];
        if (rs_s == {NB_REG{1'b0}}) begin
            rdata_1_s = {NB_DATA{1'b0}};
        end else if (wb_en_s && (i_wb_addr == rs_s)) begin
            rdata_1_s = i_wb_data;
        end else begin
            rdata_1_s = regfile_r[rs_s];
        end
        if (rt_s == {NB_REG{1'b0}}) begin
            rdata_2_s = {NB_DATA{1'b0}};
        end else if (wb_en_s && (i_wb_addr == rt_s)) begin
            rdata_2_s = i_wb_data;
        end else begin
            rdata_2_s = regfile_r[rt_s];
        end
    end

    // Logical immediates are zero-extended, everything else sign-extended.
    always_comb begin
        ext_s = {NB_DATA{1'b0}};
        case (opcode_s)
            OP_ANDI, OP_ORI, OP_XORI: ext_s = NB_DATA'(imm_s);
            default:                  ext_s = NB_DATA'($signed(imm_s));
        endcase
    end

    assign hazard_s = i_valid && i_ex_mem_read && (i_ex_rt != {NB_REG{1'b0}}) &&
                      ((i_ex_rt == rs_s) || (i_ex_rt == rt_s));
    assign o_stall  = hazard_s || i_ex_stall;

    // Next ID/EX contents: flush beats stall, stall holds, hazard inserts a bubble.
    always_comb begin
        idex_next_s = idex_r;
        if (i_flush) begin
            idex_next_s = '0;
        end else if (i_ex_stall) begin
            idex_next_s = idex_r;
        end else if (hazard_s) begin
            idex_next_s = '0;
        end else begin
            idex_next_s.valid  = i_valid;
            idex_next_s.pc     = i_pc;
            idex_next_s.instr  = i_instruction;
            idex_next_s.opcode = opcode_s;
            idex_next_s.funct  = funct_s;
            idex_next_s.rs     = rs_s;
            idex_next_s.rt     = rt_s;
            idex_next_s.rd     = rd_s;
            idex_next_s.data_1 = rdata_1_s;
            idex_next_s.data_2 = rdata_2_s;
            idex_next_s.ext    = ext_s;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idex_r <= '0;
        end else begin
            idex_r <= idex_next_s;
        end
    end

    assign o_valid       = idex_r.valid;
    assign o_pc          = idex_r.pc;
    assign o_instruction = idex_r.instr;
    assign o_opcode      = idex_r.opcode;
    assign o_funct       = idex_r.funct;
    assign o_rs          = idex_r.rs;
    assign o_rt          = idex_r.rt;
    assign o_rd          = idex_r.rd;
    assign o_data_1      = idex_r.data_1;
    assign o_data_2      = idex_r.data_2;
    assign o_sign_extend = idex_r.ext;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a reference model predicts each ID/EX
// load into a queue, and the entry is popped and compared after the edge.
module tb_id_stage_pipe;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] sext;
    } exp_t;

    localparam logic [31:0] ADD_R3 = 32'h0041_1820;
    localparam logic [31:0] ADD_R4 = 32'h0080_2820;
    localparam logic [31:0] ADD_R0 = 32'h0000_0820;
    localparam logic [31:0] ORI_I  = 32'h3422_8001;
    localparam logic [31:0] ADDI_I = 32'h2022_8001;
    localparam logic [31:0] ADDI_P = 32'h2022_7FFF;
    localparam logic [31:0] ANDI_I = 32'h3022_F00F;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [31:0] i_pc;
    logic [31:0] i_instruction;
    logic        i_wb_write;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        i_ex_mem_read;
    logic [4:0]  i_ex_rt;
    logic        i_ex_stall;
    logic        i_flush;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_instruction;
    logic [5:0]  o_opcode;
    logic [5:0]  o_funct;
    logic [4:0]  o_rs;
    logic [4:0]  o_rt;
    logic [4:0]  o_rd;
    logic [31:0] o_data_1;
    logic [31:0] o_data_2;
    logic [31:0] o_sign_extend;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] model_rf [32];
    exp_t        sb [$];
    exp_t        bubble;
    exp_t        last_exp;
    exp_t        e;

    always #5 i_clk = ~i_clk;

    id_stage_pipe dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_pc(i_pc),
        .i_instruction(i_instruction), .i_wb_write(i_wb_write),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
        .i_ex_stall(i_ex_stall), .i_flush(i_flush), .o_stall(o_stall),
        .o_valid(o_valid), .o_pc(o_pc), .o_instruction(o_instruction),
        .o_opcode(o_opcode), .o_funct(o_funct), .o_rs(o_rs), .o_rt(o_rt),
        .o_rd(o_rd), .o_data_1(o_data_1), .o_data_2(o_data_2),
        .o_sign_extend(o_sign_extend)
    );

    function automatic logic [31:0] rd_model(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (i_wb_write && i_wb_addr == a) return i_wb_data;
        return model_rf[a];
    endfunction

    function automatic exp_t predict(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        exp_t r;
        logic [15:0] imm;
        imm      = ins[15:0];
        r.valid  = v;
        r.pc     = pc;
        r.instr  = ins;
        r.opcode = ins[31:26];
        r.funct  = ins[5:0];
        r.rs     = ins[25:21];
        r.rt     = ins[20:16];
        r.rd     = ins[15:11];
        r.d1     = rd_model(ins[25:21]);
        r.d2     = rd_model(ins[20:16]);
        if (r.opcode == 6'h0C || r.opcode == 6'h0D || r.opcode == 6'h0E)
            r.sext = {16'h0000, imm};
        else
            r.sext = {{16{imm[15]}}, imm};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed=empty-scoreboard expected=entry", tag);
            return;
        end
        x = sb.pop_front();
        chk({tag, ".valid"},  {31'd0, o_valid},  {31'd0, x.valid});
        chk({tag, ".pc"},     o_pc,              x.pc);
        chk({tag, ".instr"},  o_instruction,     x.instr);
        chk({tag, ".opcode"}, {26'd0, o_opcode}, {26'd0, x.opcode});
        chk({tag, ".funct"},  {26'd0, o_funct},  {26'd0, x.funct});
        chk({tag, ".rs"},     {27'd0, o_rs},     {27'd0, x.rs});
        chk({tag, ".rt"},     {27'd0, o_rt},     {27'd0, x.rt});
        chk({tag, ".rd"},     {27'd0, o_rd},     {27'd0, x.rd});
        chk({tag, ".data_1"}, o_data_1,          x.d1);
        chk({tag, ".data_2"}, o_data_2,          x.d2);
        chk({tag, ".sext"},   o_sign_extend,     x.sext);
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (i_rst_n && i_wb_write && i_wb_addr != 5'd0) model_rf[i_wb_addr] = i_wb_data;
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        i_valid       = v;
        i_pc          = pc;
        i_instruction = ins;
    endtask

    task automatic step(input exp_t x, input string tag);
        sb.push_back(x);
        tick();
        check_out(tag);
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        i_wb_write = 1'b1;
        i_wb_addr  = a;
        i_wb_data  = d;
        drive(1'b0, 32'd0, 32'd0);
        tick();
        i_wb_write = 1'b0;
    endtask

    initial begin
        bubble = '{default: '0};
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        i_rst_n = 1'b0; i_wb_write = 1'b0; i_wb_addr = 5'd0; i_wb_data = 32'd0;
        i_ex_mem_read = 1'b0; i_ex_rt = 5'd0; i_ex_stall = 1'b0; i_flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        #12;
        sb.push_back(bubble);
        check_out("reset");
        chk("reset.stall", {31'd0, o_stall}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Write/read
        wb(5'd2, 32'd2);
        wb(5'd1, 32'd5);
        drive(1'b1, 32'd1, ADD_R3);
        step(predict(1'b1, 32'd1, ADD_R3), "t1_add");
        chk("t1.data_1", o_data_1, 32'd2);
        chk("t1.data_2", o_data_2, 32'd5);
        chk("t1.rd", {27'd0, o_rd}, 32'd3);
        chk("t1.funct", {26'd0, o_funct}, 32'h20);

        // Asynchronous reset between edges clears ID/EX and the register file
        #2 i_rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        sb.push_back(bubble);
        check_out("t6_async_rst");
        i_rst_n = 1'b1;
        drive(1'b1, 32'd2, ADD_R3);
        step(predict(1'b1, 32'd2, ADD_R3), "t6_after_rst");
        chk("t6.r2_cleared", o_data_1, 32'd0);
        wb(5'd2, 32'd2);
        wb(5'd1, 32'd5);

        // Bypass and r0
        i_wb_write = 1'b1; i_wb_addr = 5'd4; i_wb_data = 32'hAB;
        drive(1'b1, 32'd3, ADD_R4);
        step(predict(1'b1, 32'd3, ADD_R4), "t2_bypass");
        chk("t2.bypass_data_1", o_data_1, 32'hAB);
        i_wb_addr = 5'd0; i_wb_data = 32'h55;
        drive(1'b1, 32'd4, ADD_R0);
        step(predict(1'b1, 32'd4, ADD_R0), "t2_r0_bypass");
        i_wb_write = 1'b0;
        step(predict(1'b1, 32'd4, ADD_R0), "t2_r0_read");
        chk("t2.r0", o_data_1, 32'd0);
        drive(1'b1, 32'd5, ADD_R4);
        step(predict(1'b1, 32'd5, ADD_R4), "t2_r4_stored");

        // Load-use hazard
        i_ex_mem_read = 1'b1; i_ex_rt = 5'd2;
        drive(1'b1, 32'd6, ADD_R3);
        #1 chk("t3.stall_rs", {31'd0, o_stall}, 32'd1);
        step(bubble, "t3_bubble_rs");
        i_ex_mem_read = 1'b0;
        #1 chk("t3.nostall", {31'd0, o_stall}, 32'd0);
        step(predict(1'b1, 32'd6, ADD_R3), "t3_issue");
        i_ex_mem_read = 1'b1; i_ex_rt = 5'd1;
        #1 chk("t3.stall_rt", {31'd0, o_stall}, 32'd1);
        step(bubble, "t3_bubble_rt");
        drive(1'b0, 32'd7, ADD_R3);
        #1 chk("t3.invalid_nostall", {31'd0, o_stall}, 32'd0);
        step(predict(1'b0, 32'd7, ADD_R3), "t3_invalid_capture");
        i_ex_rt = 5'd0;
        drive(1'b1, 32'd8, ADD_R0);
        #1 chk("t3.rt0_nostall", {31'd0, o_stall}, 32'd0);
        step(predict(1'b1, 32'd8, ADD_R0), "t3_rt0_issue");
        i_ex_mem_read = 1'b0;

        // Flush priority, then stall hold
        drive(1'b1, 32'd9, ADD_R3);
        step(predict(1'b1, 32'd9, ADD_R3), "t4_prefill");
        i_flush = 1'b1; i_ex_stall = 1'b1;
        drive(1'b1, 32'd10, ADD_R4);
        step(bubble, "t4_flush_over_stall");
        i_flush = 1'b0; i_ex_stall = 1'b0;
        drive(1'b1, 32'd11, ADD_R3);
        last_exp = predict(1'b1, 32'd11, ADD_R3);
        step(last_exp, "t4_load");
        i_ex_stall = 1'b1;
        drive(1'b1, 32'd12, ORI_I);
        for (int k = 0; k < 3; k++) begin
            #1 chk("t4.stall_out", {31'd0, o_stall}, 32'd1);
            step(last_exp, "t4_hold");
        end
        i_ex_stall = 1'b0;

        // Immediate extension
        drive(1'b1, 32'd13, ORI_I);
        step(predict(1'b1, 32'd13, ORI_I), "t5_ori");
        chk("t5.ori_zext", o_sign_extend, 32'h0000_8001);
        drive(1'b1, 32'd14, ADDI_I);
        step(predict(1'b1, 32'd14, ADDI_I), "t5_addi");
        chk("t5.addi_sext", o_sign_extend, 32'hFFFF_8001);
        drive(1'b1, 32'd15, ADDI_P);
        step(predict(1'b1, 32'd15, ADDI_P), "t5_addi_pos");
        drive(1'b1, 32'd16, ANDI_I);
        step(predict(1'b1, 32'd16, ANDI_I), "t5_andi");
        chk("t5.andi_zext", o_sign_extend, 32'h0000_F00F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
